// File: rtl/matrix_scanner.sv
// matrix_scanner: 16x16 LED matrix row scanner.
// Each row: LOAD (1 cycle) -> SHIFT (32*SCLK_DIV) -> LATCH (SCLK_DIV) -> DWELL (DWELL).
// The whole image is snapshotted at the LOAD of row 0 so each frame is consistent.
// Optional macro GREEN_PLANE_EN adds greenArray/sdata_g, shifted bit-aligned with red.
module matrix_scanner #(
  parameter int unsigned SCLK_DIV = 4,
  parameter int unsigned DWELL    = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0][15:0] redArray,
  output logic              sclk,
  output logic              sdata_r,
  output logic              slatch,
  output logic [15:0]       rowSel,
  output logic              frameDone
`ifdef GREEN_PLANE_EN
  ,
  input  logic [15:0][15:0] greenArray,
  output logic              sdata_g
`endif
);

  typedef enum logic [1:0] {
    S_LOAD,
    S_SHIFT,
    S_LATCH,
    S_DWELL
  } state_t;

  localparam logic [7:0]  DIV_LAST   = 8'(SCLK_DIV - 1);
  localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);

  state_t            state_q, state_d;
  logic [3:0]        row_q, row_d;
  logic [7:0]        div_q, div_d;
  logic [4:0]        half_q, half_d;
  logic [15:0]       dwell_q, dwell_d;
  logic              sclk_q, sclk_d;
  logic              slatch_q, slatch_d;
  logic [15:0]       rowsel_q, rowsel_d;
  logic              frame_done_q, frame_done_d;

  logic [15:0][15:0] snap_r_q, snap_r_d;
  logic [15:0]       shreg_r_q, shreg_r_d;
  logic              sdata_r_q, sdata_r_d;
  logic [15:0]       load_r;

`ifdef GREEN_PLANE_EN
  logic [15:0][15:0] snap_g_q, snap_g_d;
  logic [15:0]       shreg_g_q, shreg_g_d;
  logic              sdata_g_q, sdata_g_d;
  logic [15:0]       load_g;
`endif

  // Datapath strobes shared by every colour plane
  logic snap_en, load_en, shift_en;

  // Sequencer: state, counters and control outputs for the cycle being entered
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    div_d        = div_q;
    half_d       = half_q;
    dwell_d      = dwell_q;
    sclk_d       = sclk_q;
    slatch_d     = slatch_q;
    rowsel_d     = rowsel_q;
    snap_en      = 1'b0;
    load_en      = 1'b0;
    shift_en     = 1'b0;
    case (state_q)
      S_LOAD: begin
        snap_en = (row_q == 4'd0);
        load_en = 1'b1;
        sclk_d  = 1'b0;
        div_d   = '0;
        half_d  = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (half_q == 5'd31) begin
            sclk_d   = 1'b0;
            slatch_d = 1'b1;
            state_d  = S_LATCH;
          end else begin
            half_d   = half_q + 5'd1;
            sclk_d   = ~half_q[0];
            // a new low half-period starts the next bit
            shift_en = half_q[0];
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      S_LATCH: begin
        if (div_q == DIV_LAST) begin
          div_d    = '0;
          slatch_d = 1'b0;
          rowsel_d = 16'd1 << row_q;
          dwell_d  = '0;
          state_d  = S_DWELL;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      S_DWELL: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d  = '0;
          rowsel_d = '0;
          row_d    = row_q + 4'd1;
          state_d  = S_LOAD;
        end else begin
          dwell_d = dwell_q + 16'd1;
        end
      end
      default: state_d = S_LOAD;
    endcase
    // registered pulse lands on the final DWELL cycle of row 15
    frame_done_d = (state_d == S_DWELL) && (dwell_d == DWELL_LAST) && (row_q == 4'd15);
  end

  // Red plane: snapshot, per-row load and MSB-first shift
  always_comb begin
    snap_r_d  = snap_en ? redArray : snap_r_q;
    load_r    = (row_q == 4'd0) ? redArray[0] : snap_r_q[row_q];
    shreg_r_d = shreg_r_q;
    sdata_r_d = sdata_r_q;
    if (load_en) begin
      shreg_r_d = {load_r[14:0], 1'b0};
      sdata_r_d = load_r[15];
    end else if (shift_en) begin
      shreg_r_d = {shreg_r_q[14:0], 1'b0};
      sdata_r_d = shreg_r_q[15];
    end
  end

`ifdef GREEN_PLANE_EN
  // Green plane: identical handling, bit-aligned with red
  always_comb begin
    snap_g_d  = snap_en ? greenArray : snap_g_q;
    load_g    = (row_q == 4'd0) ? greenArray[0] : snap_g_q[row_q];
    shreg_g_d = shreg_g_q;
    sdata_g_d = sdata_g_q;
    if (load_en) begin
      shreg_g_d = {load_g[14:0], 1'b0};
      sdata_g_d = load_g[15];
    end else if (shift_en) begin
      shreg_g_d = {shreg_g_q[14:0], 1'b0};
      sdata_g_d = shreg_g_q[15];
    end
  end
`endif

  // All state and registered outputs, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_LOAD;
      row_q        <= '0;
      div_q        <= '0;
      half_q       <= '0;
      dwell_q      <= '0;
      sclk_q       <= 1'b0;
      slatch_q     <= 1'b0;
      rowsel_q     <= '0;
      frame_done_q <= 1'b0;
      snap_r_q     <= '0;
      shreg_r_q    <= '0;
      sdata_r_q    <= 1'b0;
`ifdef GREEN_PLANE_EN
      snap_g_q     <= '0;
      shreg_g_q    <= '0;
      sdata_g_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      div_q        <= div_d;
      half_q       <= half_d;
      dwell_q      <= dwell_d;
      sclk_q       <= sclk_d;
      slatch_q     <= slatch_d;
      rowsel_q     <= rowsel_d;
      frame_done_q <= frame_done_d;
      snap_r_q     <= snap_r_d;
      shreg_r_q    <= shreg_r_d;
      sdata_r_q    <= sdata_r_d;
`ifdef GREEN_PLANE_EN
      snap_g_q     <= snap_g_d;
      shreg_g_q    <= shreg_g_d;
      sdata_g_q    <= sdata_g_d;
`endif
    end
  end

  assign sclk      = sclk_q;
  assign sdata_r   = sdata_r_q;
  assign slatch    = slatch_q;
  assign rowSel    = rowsel_q;
  assign frameDone = frame_done_q;
`ifdef GREEN_PLANE_EN
  assign sdata_g   = sdata_g_q;
`endif

endmodule

// File: tb/tb_matrix_scanner.sv
// tb_matrix_scanner: scoreboard bench for matrix_scanner (SCLK_DIV=1, DWELL=4).
// Expected row images come from a frame-snapshot model keyed on elapsed cycles;
// a negedge monitor checks control timing every cycle and pops row data on slatch.
module tb_matrix_scanner;

  localparam int SD     = 1;
  localparam int DW     = 4;
  localparam int ROWP   = 1 + 33 * SD + DW;
  localparam int FRAMEP = 16 * ROWP;

  logic              clk = 1'b0;
  logic              reset;
  logic [15:0][15:0] red;
  logic              sclk, sdata_r, slatch, frameDone;
  logic [15:0]       rowSel;
`ifdef GREEN_PLANE_EN
  logic [15:0][15:0] green;
  logic              sdata_g;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] r;
    logic [15:0] g;
  } exp_t;
  exp_t exp_q[$];

  logic [15:0][15:0] img_r, img_g;
  int                cyc;
  int                pops = 0;
  int                nbits;
  logic              prev_sclk, prev_slatch, prev_sdata_r;
  logic [15:0]       col_r, col_g;

  matrix_scanner #(.SCLK_DIV(SD), .DWELL(DW)) dut (
    .clk(clk),
    .reset(reset),
    .redArray(red),
    .sclk(sclk),
    .sdata_r(sdata_r),
    .slatch(slatch),
    .rowSel(rowSel),
    .frameDone(frameDone)
`ifdef GREEN_PLANE_EN
    ,
    .greenArray(green),
    .sdata_g(sdata_g)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] out_vec();
    logic [31:0] v;
    v = {12'd0, rowSel, sclk, sdata_r, slatch, frameDone};
`ifdef GREEN_PLANE_EN
    v[31] = sdata_g;
`endif
    return v;
  endfunction

  // Monitor: reference model plus per-cycle control and scoreboard checks
  always @(negedge clk) begin
    int p, r;
    exp_t e;
    logic [15:0] e_rs;
    logic e_sl, e_sc, e_fd;
    if (reset) begin
      check("reset_outputs", out_vec(), 32'd0);
      cyc = 0; nbits = 0; col_r = '0; col_g = '0;
      prev_sclk = 1'b0; prev_slatch = 1'b0; prev_sdata_r = 1'b0;
      exp_q.delete();
    end else begin
      p = cyc % ROWP;
      r = (cyc / ROWP) % 16;
      if (p == 0) begin
        if (r == 0) begin
          img_r = red;
`ifdef GREEN_PLANE_EN
          img_g = green;
`endif
        end
        e.r = img_r[r];
        e.g = '0;
`ifdef GREEN_PLANE_EN
        e.g = img_g[r];
`endif
        exp_q.push_back(e);
      end
      e_rs = (p >= 1 + 33 * SD) ? (16'd1 << r) : 16'd0;
      e_sl = (p >= 1 + 32 * SD) && (p < 1 + 33 * SD);
      e_sc = (p >= 1) && (p < 1 + 32 * SD) && (((p - 1) / SD) % 2 == 1);
      e_fd = (p == ROWP - 1) && (r == 15);
      check("ctrl{rowSel,slatch,sclk,frameDone}", {13'd0, rowSel, slatch, sclk, frameDone},
            {13'd0, e_rs, e_sl, e_sc, e_fd});
      if (sdata_r !== prev_sdata_r) check("sdata_change_sclk_low", {31'd0, sclk}, 32'd0);
      if (sclk && !prev_sclk) begin
        col_r = {col_r[14:0], sdata_r};
`ifdef GREEN_PLANE_EN
        col_g = {col_g[14:0], sdata_g};
`endif
        nbits++;
      end
      if (slatch && !prev_slatch) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
          e = exp_q.pop_front();
          pops++;
          check("row_data_r", {16'd0, col_r}, {16'd0, e.r});
          check("bits_per_row", nbits, 16);
`ifdef GREEN_PLANE_EN
          check("row_data_g", {16'd0, col_g}, {16'd0, e.g});
          if (e.g == ~e.r) check("g_complement_r", {16'd0, col_g}, {16'd0, ~col_r});
`endif
        end
        nbits = 0;
      end
      prev_sclk = sclk; prev_slatch = slatch; prev_sdata_r = sdata_r;
      cyc++;
    end
  end

  // Stimulus
  initial begin
    int i;
    reset = 1'b0;
    for (int k = 0; k < 16; k++) red[k] = 16'($urandom);
    red[0] = 16'hA5C3;
    red[5] = 16'hFFFF;
`ifdef GREEN_PLANE_EN
    for (int k = 0; k < 16; k++) green[k] = 16'($urandom);
    green[0] = 16'h5A3C;
`endif
    #1 reset = 1'b1;
    repeat (4) @(posedge clk);
    #2 reset = 1'b0;

    // row 2 of frame 0: row 5 must still show the snapshot, next frame the new value
    repeat (2 * ROWP + 5) @(posedge clk);
    #2;
    red[5] = 16'h0000;
    red[0] = 16'hFF00;
`ifdef GREEN_PLANE_EN
    green[0] = 16'h00FF;
`endif

    // random churn on rows 1..15 over roughly two frames
    repeat (2 * FRAMEP / 20) begin
      repeat (20) @(posedge clk);
      #2;
      i = int'($urandom_range(15, 1));
      if (i != 5) red[i] = 16'($urandom);
`ifdef GREEN_PLANE_EN
      green[i] = 16'($urandom);
`endif
    end

    // reset in the middle of row 7's shift
    i = 0;
    while (!(((cyc / ROWP) % 16 == 7) && (cyc % ROWP == 1 + 16 * SD)) && i < 2 * FRAMEP) begin
      @(posedge clk);
      #2;
      i++;
    end
    if (i >= 2 * FRAMEP) check("wait_row7_shift", 32'd0, 32'd1);
    reset = 1'b1;
    #1 check("async_reset_outputs", out_vec(), 32'd0);
    repeat (3) @(posedge clk);
    #2;
    for (int k = 0; k < 16; k++) red[k] = 16'($urandom);
    reset = 1'b0;
    repeat (FRAMEP + 2 * ROWP) @(posedge clk);
    #2;
    check("rows_scored_min40", {31'd0, pops >= 40}, 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #(100000 * 10);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
